adder_counter: RTL and testbench
================================

Name: adder_counter

Overview:
- Synchronous up-counter, WIDTH bits wide, driven by a single-cycle increment strobe and a synchronous clear.
- Used as a small event or occurrence counter inside datapath and control blocks; the count is read directly from a registered output.
- Port order is fixed as listed below because instantiations connect ports positionally: clock, reset, clr, inc, out. Optional ports are appended after out.

Parameters:
- WIDTH, 8, width of the count output in bits; legal range 1..32.
- SATURATE, 0, 0 = wrap from all-ones to 0; 1 = hold at all-ones.

Ports:
- aclk  input  1  clock; all state updates on the rising edge.
- srst  input  1  synchronous active-high reset.
- clr  input  1  synchronous clear of the count; 1-cycle pulse or held.
- inc  input  1  increment request; each cycle sampled high adds 1.
- out  output  WIDTH  current count, registered.
- wrap  output  1  registered 1-cycle pulse on the cycle after the count wraps from all-ones to 0. Always 0 when SATURATE=1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port aclk, reset port srst.
- Reset: on a rising aclk edge with srst=1, out<=0 and wrap<=0. srst overrides clr and inc. Asserting reset mid-count clears the count on the next edge.
- Update priority per rising edge is srst > clr > inc > hold:
  - clr=1: out<=0, regardless of inc.
  - clr=0 and inc=1: out<=out+1, modulo 2^WIDTH.
  - Otherwise: out holds its value.
- Latency: out reflects inc or clr one cycle after sampling. There is no combinational path from any input to out.
- Wrap-around with SATURATE=0: all-ones plus inc gives 0, and wrap=1 for exactly that following cycle.
- Saturation with SATURATE=1: all-ones plus inc stays all-ones; wrap stays 0.
- Inputs are sampled only at the clock edge. There is no handshake; every sampled inc counts.
- After reset release with inc=0 and clr=0, out stays 0 indefinitely.
- No X propagation: out is defined from the first reset edge onward.

Optional Feature:
- Macro ADDER_COUNTER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), appended after wrap.
  - ovf is a sticky flag that sets on the same edge wrap would assert. With SATURATE=1, it instead sets on the first inc attempted while out is all-ones.
  - ovf clears only on srst or clr.
- When not defined: the ovf port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package adder_counter_pkg holds:
  - localparam defaults: ADDER_DEFAULT_WIDTH = 8.
  - Function cnt_max(width), which returns all-ones for the given width.
- A sub-module is not needed. Optionally, a single next-count function (inc, clr, saturate rules) lives in the package and is shared with any sibling counters.

Test Plan:
- Reset, WIDTH=8: hold srst=1, inc=0, clr=0 for 25 cycles, release -> out=0, wrap=0. inc=0 for 2 more cycles -> out still 0.
- Single increment: inc=1 for one cycle -> out=1 on the next cycle; inc=0 afterwards -> out stays 1, and out is not equal to 0.
- Continuous count and wrap, SATURATE=0: inc=1 for 256 cycles from 0 -> out=0 and wrap=1 for exactly one cycle. With OVF_EN defined, ovf=1 and stays 1.
- Saturation, SATURATE=1: inc=1 for 300 cycles -> out=255 (8'hFF) and holds; wrap never asserts; ovf=1 if enabled.
- Clear priority: with out=5, drive clr=1 and inc=1 in the same cycle -> out=0 next cycle. Release clr with inc=1 -> out=1.
- Reset mid-operation: with out=100 and inc=1, assert srst for one cycle -> out=0 next cycle, overriding inc and clearing ovf.

Source files
------------

// File: rtl/adder_counter_pkg.sv
// Shared definitions for adder_counter and sibling counters.
package adder_counter_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 8;

  // All-ones value for a counter of the given width (1..32), zero-extended to 32 bits.
  function automatic logic [31:0] cnt_max(input int width);
    if (width >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/adder_counter.sv
// adder_counter: WIDTH-bit synchronous up-counter with clear, increment strobe,
// wrap pulse and optional saturation.
// Optional sticky overflow flag 'ovf' appended after 'wrap' when the macro
// ADDER_COUNTER_OVF_EN is defined.
module adder_counter
  import adder_counter_pkg::*;
#(
  parameter int WIDTH    = ADDER_DEFAULT_WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] out,
  output logic             wrap
`ifdef ADDER_COUNTER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_max;
`ifdef ADDER_COUNTER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign at_max = (cnt_q == MAX);

  // Next-state: clr beats inc; at all-ones either wrap (pulse) or hold.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
`ifdef ADDER_COUNTER_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (clr) begin
      cnt_d = '0;
`ifdef ADDER_COUNTER_OVF_EN
      ovf_d = 1'b0;
`endif
    end else if (inc) begin
      if (at_max) begin
        if (!SATURATE) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
`ifdef ADDER_COUNTER_OVF_EN
        // Sets on the wrapping edge, or on the first inc attempted at all-ones
        // when saturating.
        ovf_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  // State registers; synchronous reset overrides everything.
  always_ff @(posedge aclk) begin
    if (srst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
`ifdef ADDER_COUNTER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
`ifdef ADDER_COUNTER_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign out  = cnt_q;
  assign wrap = wrap_q;
`ifdef ADDER_COUNTER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_adder_counter.sv
// Directed bench for adder_counter: one wrapping and one saturating instance,
// WIDTH=8, driven by shared inputs. Checks ovf when ADDER_COUNTER_OVF_EN is defined.
module tb_adder_counter;

  logic       aclk = 1'b0;
  logic       srst, clr, inc;
  logic [7:0] out_w, out_s;
  logic       wrap_w, wrap_s;
`ifdef ADDER_COUNTER_OVF_EN
  logic       ovf_w, ovf_s;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int wrap_pulses_w, wrap_pulses_s;

  always #5 aclk = ~aclk;

  adder_counter #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .aclk(aclk), .srst(srst), .clr(clr), .inc(inc), .out(out_w), .wrap(wrap_w)
`ifdef ADDER_COUNTER_OVF_EN
    , .ovf(ovf_w)
`endif
  );

  adder_counter #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .aclk(aclk), .srst(srst), .clr(clr), .inc(inc), .out(out_s), .wrap(wrap_s)
`ifdef ADDER_COUNTER_OVF_EN
    , .ovf(ovf_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs, advance one edge, then settle 1 time unit past it for sampling.
  task automatic step(input logic r, input logic c, input logic i);
    srst = r; clr = c; inc = i;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    srst = 1'b1; clr = 1'b0; inc = 1'b0;

    // Reset held 25 cycles
    repeat (25) step(1'b1, 1'b0, 1'b0);
    chk("rst_out_w", out_w, 0);
    chk("rst_wrap_w", wrap_w, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_wrap_s", wrap_s, 0);
`ifdef ADDER_COUNTER_OVF_EN
    chk("rst_ovf_w", ovf_w, 0);
    chk("rst_ovf_s", ovf_s, 0);
`endif
    repeat (2) step(1'b0, 1'b0, 1'b0);
    chk("idle_out_w", out_w, 0);
    chk("idle_out_s", out_s, 0);

    // Single increment, then hold
    step(1'b0, 1'b0, 1'b1);
    chk("inc1_out_w", out_w, 1);
    chk("inc1_out_s", out_s, 1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("hold_out_w", out_w, 1);
    chk("hold_nonzero_w", (out_w != 8'd0), 1);

    // Clear priority over inc at out=5
    repeat (4) step(1'b0, 1'b0, 1'b1);
    chk("five_out_w", out_w, 5);
    step(1'b0, 1'b1, 1'b1);
    chk("clrinc_out_w", out_w, 0);
    chk("clrinc_out_s", out_s, 0);
    step(1'b0, 1'b0, 1'b1);
    chk("postclr_out_w", out_w, 1);
    step(1'b0, 1'b1, 1'b0);
    chk("clr_out_w", out_w, 0);

    // 300 increments from 0: wrap instance wraps once at the 256th, saturating holds at 255
    wrap_pulses_w = 0;
    wrap_pulses_s = 0;
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 1'b0, 1'b1);
      if (wrap_w) wrap_pulses_w++;
      if (wrap_s) wrap_pulses_s++;
      if (k == 255) begin
        chk("k255_out_w", out_w, 255);
        chk("k255_wrap_w", wrap_w, 0);
`ifdef ADDER_COUNTER_OVF_EN
        chk("k255_ovf_w", ovf_w, 0);
        chk("k255_ovf_s", ovf_s, 0);
`endif
      end
      if (k == 256) begin
        chk("k256_out_w", out_w, 0);
        chk("k256_wrap_w", wrap_w, 1);
        chk("k256_out_s", out_s, 255);
`ifdef ADDER_COUNTER_OVF_EN
        chk("k256_ovf_w", ovf_w, 1);
        chk("k256_ovf_s", ovf_s, 1);
`endif
      end
      if (k == 257) chk("k257_wrap_w", wrap_w, 0);
    end
    chk("run_out_w", out_w, 44);
    chk("run_out_s", out_s, 255);
    chk("wrap_pulses_w", wrap_pulses_w, 1);
    chk("wrap_pulses_s", wrap_pulses_s, 0);
`ifdef ADDER_COUNTER_OVF_EN
    chk("run_ovf_w", ovf_w, 1);
    chk("run_ovf_s", ovf_s, 1);
`endif

    // Count on to 100, then mid-count reset overrides inc
    repeat (56) step(1'b0, 1'b0, 1'b1);
    chk("hundred_out_w", out_w, 100);
    chk("hundred_out_s", out_s, 255);
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_out_w", out_w, 0);
    chk("midrst_out_s", out_s, 0);
    chk("midrst_wrap_w", wrap_w, 0);
`ifdef ADDER_COUNTER_OVF_EN
    chk("midrst_ovf_w", ovf_w, 0);
    chk("midrst_ovf_s", ovf_s, 0);
`endif
    step(1'b0, 1'b0, 1'b1);
    chk("postrst_out_w", out_w, 1);
    chk("postrst_out_s", out_s, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
